// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg
// Shared definitions for the counter sequencer slice: controller state
// encoding and the direction constants used on cmd_dir.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if
// Command bus into the counter sequencer.
//   cmd_valid  master -> slave  a command is presented
//   cmd_ready  slave  -> master controller can take a command
//   cmd_dir    master -> slave  1 = count up, 0 = count down
//   cmd_start  master -> slave  value loaded into the counter on accept
//   cmd_end    master -> slave  terminal value
//   cmd_div    master -> slave  step every cmd_div+1 cycles
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. The master keeps the command fields stable while
// cmd_valid is high and not yet accepted; cmd_ready does not depend on
// cmd_valid.
interface counter_sequencer_if #(
    parameter int WIDTH     = 4,
    parameter int DIV_WIDTH = 4
) ();
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_dir;
    logic [WIDTH-1:0]     cmd_start;
    logic [WIDTH-1:0]     cmd_end;
    logic [DIV_WIDTH-1:0] cmd_div;

    modport master (
        output cmd_valid, cmd_dir, cmd_start, cmd_end, cmd_div,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_start, cmd_end, cmd_div,
        output cmd_ready
    );
endinterface

// File: rtl/counter_step_core.sv
// counter_step_core
// WIDTH-bit loadable up/down counter register.
//   clk, reset  clock, synchronous active-high reset (q -> 0)
//   load        load load_value (has priority over en)
//   load_value  value to load
//   en          apply one +/-1 step
//   dir         DIR_UP / DIR_DOWN
//   q           current value
//   q_step      value q would take on a step (wraps modulo 2^WIDTH)
module counter_step_core
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_step
);

    // Natural modulo-2^WIDTH wrap of the WIDTH-bit add/subtract.
    assign q_step = (dir == DIR_UP) ? q + WIDTH'(1) : q - WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_value;
        end else if (en) begin
            q <= q_step;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer
// Accepts one count job at a time (start, end, direction, step rate) and
// steps a counter through a prescaler until the end value is reached, then
// pulses done for one cycle.
//   clk, reset  clock, synchronous active-high reset
//   cmd         command bus (slave side), see counter_sequencer_if
//   pause       freeze stepping and prescaler while high (RUN only)
//   abort       cancel the running job, no done pulse (RUN only)
//   Q           counter value
//   busy        job in progress
//   done        one-cycle completion pulse
//   state_dbg   current controller state
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DIV_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    counter_sequencer_if.slave  cmd,
    input  logic                pause,
    input  logic                abort,
    output logic [WIDTH-1:0]    Q,
    output logic                busy,
    output logic                done,
    output state_t              state_dbg
);

    state_t               state_q, state_d;
    logic                 dir_q;
    logic [WIDTH-1:0]     end_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] presc_q, presc_d;
    logic                 accept;
    logic                 step;
    logic [WIDTH-1:0]     q_step;

    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);
    assign state_dbg     = state_q;
    assign accept        = cmd.cmd_valid && (state_q == ST_IDLE);

    counter_step_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (cmd.cmd_start),
        .en         (step),
        .dir        (dir_q),
        .q          (Q),
        .q_step     (q_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            dir_q   <= DIR_DOWN;
            end_q   <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            if (accept) begin
                dir_q <= cmd.cmd_dir;
                end_q <= cmd.cmd_end;
                div_q <= cmd.cmd_div;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        step    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // abort has no effect here, even alongside an accept.
                if (accept) begin
                    presc_d = '0;
                    state_d = (cmd.cmd_start == cmd.cmd_end) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    presc_d = presc_q;
                end else if (presc_q == div_q) begin
                    step    = 1'b1;
                    presc_d = '0;
                    // Compare the post-step value so DONE follows the final step directly.
                    if (q_step == end_q) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    presc_d = presc_q + DIV_WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;
    import counter_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       pause;
    logic       abort;
    logic [3:0] Q;
    logic       busy;
    logic       done;
    state_t     state_dbg;

    int checks = 0;
    int errors = 0;

    counter_sequencer_if #(.WIDTH(4), .DIV_WIDTH(4)) cmd_if ();

    counter_sequencer #(.WIDTH(4), .DIV_WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd_if),
        .pause     (pause),
        .abort     (abort),
        .Q         (Q),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected counter value after a number of completed steps from start.
    function automatic int model_q(input int start, input int dir, input int steps);
        return (dir != 0) ? ((start + steps) & 15) : ((start - steps) & 15);
    endfunction

    // Drives one job and checks every cycle against the arithmetic model:
    // after t unpaused RUN cycles the counter has made t/(div+1) steps, and
    // the job ends once it has made n steps. lat returns the number of RUN
    // cycles until done (0 for zero-length, -1 for aborted).
    task automatic run_job(input int start, input int fin, input int dir, input int div,
                           input int p_start, input int p_len, input int ab_cyc,
                           input bit ab_on_accept, input string tag, output int lat);
        int  n;
        int  ticks;
        int  steps;
        int  expq;
        bit  paused;
        bit  ab;
        bit  finished;
        lat = -1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_start = 4'(start);
        cmd_if.cmd_end   = 4'(fin);
        cmd_if.cmd_dir   = dir[0];
        cmd_if.cmd_div   = 4'(div);
        abort = ab_on_accept;
        tick();
        cmd_if.cmd_valid = 1'b0;
        abort = 1'b0;
        n = (dir != 0) ? ((fin - start) & 15) : ((start - fin) & 15);
        chk({tag, "_load_q"}, Q, start);
        if (n == 0) begin
            chk({tag, "_zl_done"}, done, 1);
            chk({tag, "_zl_busy"}, busy, 0);
            chk({tag, "_zl_ready"}, cmd_if.cmd_ready, 0);
            tick();
            chk({tag, "_zl_ready_back"}, cmd_if.cmd_ready, 1);
            chk({tag, "_zl_done_low"}, done, 0);
            chk({tag, "_zl_q"}, Q, fin);
            lat = 0;
            return;
        end
        chk({tag, "_busy_start"}, busy, 1);
        chk({tag, "_ready_start"}, cmd_if.cmd_ready, 0);
        ticks = 0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            paused = (cyc >= p_start) && (cyc < p_start + p_len);
            ab     = (cyc == ab_cyc);
            pause  = paused;
            abort  = ab;
            expq   = model_q(start, dir, ticks / (div + 1));
            tick();
            pause = 1'b0;
            abort = 1'b0;
            if (ab) begin
                chk({tag, "_abort_q"}, Q, expq);
                chk({tag, "_abort_busy"}, busy, 0);
                chk({tag, "_abort_ready"}, cmd_if.cmd_ready, 1);
                chk({tag, "_abort_done"}, done, 0);
                tick();
                chk({tag, "_abort_no_done"}, done, 0);
                chk({tag, "_abort_q_hold"}, Q, expq);
                finished = 1'b1;
            end else begin
                if (!paused) ticks++;
                steps = ticks / (div + 1);
                chk({tag, "_q"}, Q, model_q(start, dir, steps));
                if (steps == n) begin
                    chk({tag, "_done"}, done, 1);
                    chk({tag, "_busy_end"}, busy, 0);
                    chk({tag, "_ready_in_done"}, cmd_if.cmd_ready, 0);
                    tick();
                    chk({tag, "_done_pulse"}, done, 0);
                    chk({tag, "_ready_back"}, cmd_if.cmd_ready, 1);
                    chk({tag, "_q_end"}, Q, fin);
                    lat = cyc + 1;
                    finished = 1'b1;
                end else begin
                    chk({tag, "_busy"}, busy, 1);
                    chk({tag, "_done_low"}, done, 0);
                end
            end
        end
        if (!finished) chk({tag, "_timeout"}, 1, 0);
    endtask

    initial begin
        int lat;
        int ab;
        reset = 1'b1;
        pause = 1'b0;
        abort = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_start = '0;
        cmd_if.cmd_end   = '0;
        cmd_if.cmd_div   = '0;
        tick();
        tick();
        chk("rst_q", Q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_if.cmd_ready, 1);
        chk("rst_state", state_dbg, ST_IDLE);
        reset = 1'b0;
        tick();
        chk("idle_ready", cmd_if.cmd_ready, 1);

        // Up, no prescale.
        run_job(3, 7, 1, 0, 99, 0, -1, 1'b0, "up", lat);
        chk("up_latency", lat, 4);

        // Down through the wrap.
        run_job(1, 14, 0, 0, 99, 0, -1, 1'b0, "down_wrap", lat);
        chk("down_latency", lat, 3);

        // Prescale without and with a 4-cycle pause.
        run_job(0, 2, 1, 2, 99, 0, -1, 1'b0, "presc", lat);
        chk("presc_latency", lat, 6);
        run_job(0, 2, 1, 2, 2, 4, -1, 1'b0, "presc_pause", lat);
        chk("pause_latency", lat, 10);

        // Zero-length job.
        run_job(9, 9, 1, 3, 99, 0, -1, 1'b0, "zero", lat);
        chk("zero_latency", lat, 0);

        // Abort while Q=5.
        run_job(0, 15, 1, 0, 99, 0, 5, 1'b0, "abort", lat);
        chk("abort_latency", lat, -1);

        // abort alongside an accept in IDLE is ignored.
        run_job(4, 6, 1, 0, 99, 0, -1, 1'b1, "abort_idle", lat);
        chk("abort_idle_latency", lat, 2);

        // Full-range up job: 15 steps with wrap.
        run_job(15, 14, 1, 0, 99, 0, -1, 1'b0, "full_up", lat);
        chk("full_up_latency", lat, 15);

        // Reset mid-RUN with cmd_valid held high.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_start = 4'd0;
        cmd_if.cmd_end   = 4'd15;
        cmd_if.cmd_dir   = 1'b1;
        cmd_if.cmd_div   = 4'd0;
        tick();
        cmd_if.cmd_start = 4'd11;
        cmd_if.cmd_end   = 4'd12;
        for (int i = 0; i < 6; i++) tick();
        chk("rstrun_q6", Q, 6);
        chk("rstrun_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstrun_q", Q, 0);
        chk("rstrun_busy0", busy, 0);
        chk("rstrun_done0", done, 0);
        chk("rstrun_ready", cmd_if.cmd_ready, 1);
        tick();
        cmd_if.cmd_valid = 1'b0;
        chk("held_accept_q", Q, 11);
        chk("held_accept_busy", busy, 1);
        tick();
        chk("held_q_end", Q, 12);
        chk("held_done", done, 1);
        tick();
        chk("held_ready", cmd_if.cmd_ready, 1);
        chk("held_done_low", done, 0);

        // Randomized jobs.
        for (int j = 0; j < 24; j++) begin
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
            run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 20)), int'($urandom_range(0, 5)),
                    ab, 1'($urandom_range(0, 1)), "rand", lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Command-driven controller for a loadable up/down binary counter. It accepts one count job at a time over a valid/ready handshake: start value, end value, direction and step rate. It then steps the counter with a programmable prescaler until the end value is reached, and flags completion. It sits between control logic and the counter datapath, and replaces hard-wired reset-to-start-value counters with run-time sequencing.

## Interface
- WIDTH, 4, counter width in bits
- DIV_WIDTH, 4, prescaler divide-field width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command (high only in IDLE)
- cmd_dir  in  1  1 = count up, 0 = count down
- cmd_start  in  WIDTH  value loaded into Q on accept
- cmd_end  in  WIDTH  terminal value
- cmd_div  in  DIV_WIDTH  step every cmd_div+1 cycles
- pause  in  1  freeze stepping and prescaler while high
- abort  in  1  cancel the running job
- Q  out  WIDTH  counter value
- busy  out  1  job in progress (RUN state)
- done  out  1  one-cycle completion pulse

## Operation
- Reset: state IDLE; Q=0, prescaler=0, busy=0, done=0, cmd_ready=1.
- States: IDLE, RUN, DONE. Outputs are decoded from state: cmd_ready=(IDLE), busy=(RUN), done=(DONE).
- IDLE: on cmd_valid&&cmd_ready, Q<=cmd_start and dir, end and div are latched; prescaler<=0.
  - If cmd_start==cmd_end, the next state is DONE. Otherwise it is RUN.
  - abort is ignored in IDLE, including when it arrives in the same cycle as an accept.
- RUN, in priority order:
  - abort: go to IDLE; Q holds its current value; no done pulse.
  - pause: Q and prescaler hold.
  - prescaler==div: Q<=Q±1 modulo 2^WIDTH; prescaler<=0. If the new Q equals end, go to DONE.
  - Otherwise: prescaler+1.
- DONE: done=1 for exactly one cycle, then IDLE. Q holds the end value.
- Arithmetic wraps: up from 2^WIDTH−1 goes to 0; down from 0 goes to 2^WIDTH−1. The end value is always reached within 2^WIDTH−1 steps.
- Commands presented while not in IDLE are not accepted. cmd_valid may stay high; the command is taken in the first IDLE cycle.
- A reset asserted in any state overrides everything: reset values apply after that edge, and any job in flight is lost without a done pulse.

## Timing
- Accept at edge k: Q=cmd_start is visible after edge k.
- Steps occur at edges k+m·(div+1), m=1..n, where n = (end−start) mod 2^WIDTH for up, and (start−end) mod 2^WIDTH for down.
- done is high in the cycle after edge k+n·(div+1). cmd_ready returns after edge k+n·(div+1)+1.
- start==end: done is high in the cycle after edge k; cmd_ready returns after edge k+1.
- Each paused cycle adds exactly one cycle of latency.
- abort sampled at edge j: busy=0 and cmd_ready=1 after edge j.
- Minimum spacing between accepts is 2 cycles (accept → DONE → IDLE).

## Structure
- Package counter_seq_pkg holds:
  - State encodings ST_IDLE, ST_RUN, ST_DONE (2-bit).
  - DIR_UP=1, DIR_DOWN=0.
- Sub-module counter_step_core holds the WIDTH-bit register and its controls: synchronous load, enable, direction, and the wrap-around ±1.
- The FSM, prescaler and terminal compare stay in counter_sequencer.

## Test plan
- Up, no prescale: start=3, end=7, dir=1, div=0 → Q 3,4,5,6,7 on consecutive edges; done for one cycle after Q=7; cmd_ready high the following cycle.
- Down with wrap: start=1, end=14, dir=0, div=0 → Q 1,0,15,14; done once; busy low afterward.
- Prescale plus pause: start=0, end=2, dir=1, div=2 → Q steps every 3 cycles. Holding pause for 4 cycles mid-run delays done by exactly 4 cycles.
- Zero-length job: start=end=9 → no RUN cycle; done high in the cycle after accept; Q=9.
- Abort: start=0, end=15, up, div=0, abort when Q=5 → IDLE next cycle; Q stays 5; no done. abort asserted in IDLE together with cmd_valid → command accepted.
- Reset mid-RUN: reset at Q=6 → after that edge Q=0, busy=0, done=0, cmd_ready=1. A held cmd_valid is accepted in the next cycle.
